// File: rtl/input_cond_pkg.sv
// Shared types and sizing helpers for the input event conditioner.
package input_cond_pkg;

  // Debounce FSM states; encodings are fixed so traces match across blocks.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } cond_state_e;

  // Timer width for the default debounce length.
  localparam int TMR_W_DEFAULT = $clog2(4 + 1);

  // Timer width for an arbitrary debounce length.
  function automatic int tmr_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/input_event_conditioner_sync.sv
// N-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw bit through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_event_conditioner.sv
// Synchronise, debounce and edge-detect a raw input; count accepted rising edges.
module input_event_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             raw_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             x_pulse,
  output logic             x_level,
  output logic             glitch,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int TMR_W = tmr_width(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic             sync_q;
  cond_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             enter_high;
  logic             glitch_d;
  logic             pulse_d;
  logic             level_d;
  logic             x_pulse_q, x_level_q, glitch_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (raw_in),
    .q_o (sync_q)
  );

  // State and timer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LOW;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Debounce next-state: a level change needs DEBOUNCE_CYCLES equal samples.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    glitch_d   = 1'b0;
    enter_high = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d    = S_HIGH;
            enter_high = 1'b1;
          end else begin
            state_d = S_RISE;
            timer_d = TMR_ONE;
          end
        end
      end
      S_RISE: begin
        if (!sync_q) begin
          state_d  = S_LOW;
          timer_d  = '0;
          glitch_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d    = S_HIGH;
          timer_d    = '0;
          enter_high = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = S_LOW;
          end else begin
            state_d = S_FALL;
            timer_d = TMR_ONE;
          end
        end
      end
      S_FALL: begin
        if (sync_q) begin
          // Fall aborted: return to high without a pulse.
          state_d  = S_HIGH;
          timer_d  = '0;
          glitch_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_LOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        timer_d = '0;
      end
    endcase
  end

  // Output and counter next-state; clear beats a simultaneous increment.
  always_comb begin
    pulse_d = enter_high & en;
    level_d = (state_d == S_HIGH) || (state_d == S_FALL);
    cnt_d   = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (pulse_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs and saturating event counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_pulse_q <= 1'b0;
      x_level_q <= 1'b0;
      glitch_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      x_pulse_q <= pulse_d;
      x_level_q <= level_d;
      glitch_q  <= glitch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x_pulse   = x_pulse_q;
  assign x_level   = x_level_q;
  assign glitch    = glitch_q;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_input_event_conditioner.sv
// Directed bench for input_event_conditioner (default, CNT_W=3 and DEBOUNCE_CYCLES=1 instances).
module tb_input_event_conditioner;

  logic       clk = 1'b0;
  logic       rstn;
  logic       raw_in;
  logic       en;
  logic       clr_cnt;

  logic       xp, xl, gl;
  logic [7:0] cnt;
  logic       xp3, xl3, gl3;
  logic [2:0] cnt3;
  logic       xp1, xl1, gl1;
  logic [7:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_event_conditioner dut (
    .clk(clk), .rstn(rstn), .raw_in(raw_in), .en(en), .clr_cnt(clr_cnt),
    .x_pulse(xp), .x_level(xl), .glitch(gl), .event_cnt(cnt)
  );

  input_event_conditioner #(.CNT_W(3)) dut3 (
    .clk(clk), .rstn(rstn), .raw_in(raw_in), .en(en), .clr_cnt(clr_cnt),
    .x_pulse(xp3), .x_level(xl3), .glitch(gl3), .event_cnt(cnt3)
  );

  input_event_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rstn(rstn), .raw_in(raw_in), .en(en), .clr_cnt(clr_cnt),
    .x_pulse(xp1), .x_level(xl1), .glitch(gl1), .event_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn    = 1'b0;
    raw_in  = 1'b0;
    en      = 1'b1;
    clr_cnt = 1'b0;
    tick(3);
    chk("rst_pulse", {31'd0, xp}, 32'd0);
    chk("rst_level", {31'd0, xl}, 32'd0);
    chk("rst_glitch", {31'd0, gl}, 32'd0);
    chk("rst_cnt", {24'd0, cnt}, 32'd0);
    rstn = 1'b1;

    // Clean rise: pulse after edge 6 (edge 3 for DEBOUNCE_CYCLES=1)
    raw_in = 1'b1;
    tick(2);
    chk("t1_dc1_level_e2", {31'd0, xl1}, 32'd0);
    tick(1);
    chk("t1_dc1_pulse_e3", {31'd0, xp1}, 32'd1);
    chk("t1_dc1_level_e3", {31'd0, xl1}, 32'd1);
    chk("t1_dc1_cnt_e3", {24'd0, cnt1}, 32'd1);
    chk("t1_level_e3", {31'd0, xl}, 32'd0);
    tick(2);
    chk("t1_pulse_e5", {31'd0, xp}, 32'd0);
    chk("t1_level_e5", {31'd0, xl}, 32'd0);
    tick(1);
    chk("t1_pulse_e6", {31'd0, xp}, 32'd1);
    chk("t1_level_e6", {31'd0, xl}, 32'd1);
    chk("t1_cnt_e6", {24'd0, cnt}, 32'd1);
    tick(1);
    chk("t1_pulse_e7", {31'd0, xp}, 32'd0);
    chk("t1_level_e7", {31'd0, xl}, 32'd1);
    chk("t1_dc1_pulse_e7", {31'd0, xp1}, 32'd0);

    // Clean fall, then clear the count
    raw_in = 1'b0;
    tick(5);
    chk("fall_level_e5", {31'd0, xl}, 32'd1);
    tick(1);
    chk("fall_level_e6", {31'd0, xl}, 32'd0);
    chk("fall_pulse_e6", {31'd0, xp}, 32'd0);
    tick(2);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    chk("clr_cnt", {24'd0, cnt}, 32'd0);

    // Rise aborted once: raw 1,1,0 then 1 steady
    raw_in = 1'b1;
    tick(2);
    raw_in = 1'b0;
    tick(1);
    raw_in = 1'b1;
    tick(1);
    chk("t2_glitch_e4", {31'd0, gl}, 32'd0);
    tick(1);
    chk("t2_glitch_e5", {31'd0, gl}, 32'd1);
    chk("t2_level_e5", {31'd0, xl}, 32'd0);
    tick(1);
    chk("t2_glitch_e6", {31'd0, gl}, 32'd0);
    tick(2);
    chk("t2_pulse_e8", {31'd0, xp}, 32'd0);
    tick(1);
    chk("t2_pulse_e9", {31'd0, xp}, 32'd1);
    chk("t2_cnt_e9", {24'd0, cnt}, 32'd1);
    tick(1);
    chk("t2_pulse_e10", {31'd0, xp}, 32'd0);

    // Fall aborted from high: raw 0 for 3 cycles then 1
    raw_in = 1'b0;
    tick(3);
    raw_in = 1'b1;
    tick(2);
    chk("t3_level_e5", {31'd0, xl}, 32'd1);
    chk("t3_glitch_e5", {31'd0, gl}, 32'd0);
    tick(1);
    chk("t3_glitch_e6", {31'd0, gl}, 32'd1);
    chk("t3_level_e6", {31'd0, xl}, 32'd1);
    chk("t3_pulse_e6", {31'd0, xp}, 32'd0);
    tick(1);
    chk("t3_glitch_e7", {31'd0, gl}, 32'd0);
    chk("t3_pulse_e7", {31'd0, xp}, 32'd0);
    chk("t3_cnt", {24'd0, cnt}, 32'd1);

    // Nine clean press/release cycles: 3-bit counter saturates at 7
    for (int i = 0; i < 9; i++) begin
      raw_in = 1'b0;
      tick(8);
      raw_in = 1'b1;
      tick(8);
    end
    chk("t4_cnt3_sat", {29'd0, cnt3}, 32'd7);
    chk("t4_cnt8", {24'd0, cnt}, 32'd10);
    raw_in = 1'b0;
    tick(8);
    raw_in = 1'b1;
    tick(5);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    chk("t4_clr_pulse", {31'd0, xp3}, 32'd1);
    chk("t4_clr_cnt3", {29'd0, cnt3}, 32'd0);
    chk("t4_clr_cnt8", {24'd0, cnt}, 32'd0);

    // en=0 during a rise: level follows, no pulse, no count
    raw_in = 1'b0;
    tick(8);
    en     = 1'b0;
    raw_in = 1'b1;
    tick(6);
    chk("t5_level_en0", {31'd0, xl}, 32'd1);
    chk("t5_pulse_en0", {31'd0, xp}, 32'd0);
    chk("t5_cnt_en0", {24'd0, cnt}, 32'd0);
    tick(2);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_pulse_en_raise", {31'd0, xp}, 32'd0);
    end
    raw_in = 1'b0;
    tick(8);
    raw_in = 1'b1;
    tick(6);
    chk("t5_pulse_next", {31'd0, xp}, 32'd1);
    chk("t5_cnt_next", {24'd0, cnt}, 32'd1);

    // Reset asserted while in S_RISE with raw held high
    raw_in = 1'b0;
    tick(8);
    raw_in = 1'b1;
    tick(4);
    rstn = 1'b0;
    #2;
    chk("t6_rst_cnt", {24'd0, cnt}, 32'd0);
    chk("t6_rst_level", {31'd0, xl}, 32'd0);
    chk("t6_rst_pulse", {31'd0, xp}, 32'd0);
    chk("t6_rst_glitch", {31'd0, gl}, 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(5);
    chk("t6_pulse_e5", {31'd0, xp}, 32'd0);
    tick(1);
    chk("t6_pulse_e6", {31'd0, xp}, 32'd1);
    chk("t6_level_e6", {31'd0, xl}, 32'd1);
    chk("t6_cnt_e6", {24'd0, cnt}, 32'd1);
    tick(1);
    chk("t6_pulse_e7", {31'd0, xp}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
